// File: rtl/piano_note_addr_gen_if.sv
// Key-to-ROM-address bus for the piano note address generator.
// No valid/ready pair: key is a raw level; addr is always valid and sample_tick marks the cycle it advances.
interface piano_note_addr_gen_if;
    logic [7:0] key;
    logic [4:0] addr;
    logic       sample_tick;
    logic       note_active;
    logic [2:0] note_idx;
    logic [1:0] state;

    modport master (
        input  key,
        output addr,
        output sample_tick,
        output note_active,
        output note_idx,
        output state
    );

    modport slave (
        output key,
        input  addr,
        input  sample_tick,
        input  note_active,
        input  note_idx,
        input  state
    );
endinterface

// File: rtl/piano_note_addr_gen.sv
// Steps a 5-bit waveform ROM address at 32x the selected piano note frequency,
// always finishing a note on a complete waveform cycle so release is click-free.
module piano_note_addr_gen #(
    parameter int CLK_HZ    = 12000000,
    parameter int DIV_SHIFT = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    piano_note_addr_gen_if.master bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // The divisor table below is computed for CLK_HZ; it is not derived from it.
    if (CLK_HZ < 1) begin : g_bad_clk
        $error("CLK_HZ must be positive");
    end

    state_t      state_q;
    logic [7:0]  key_meta;
    logic [7:0]  ks;
    logic [2:0]  sel;
    logic        any_key;
    logic [10:0] cnt;
    logic [10:0] cur_div;
    logic        tick_now;
    logic        wrap;
    logic [4:0]  addr_q;
    logic        tick_q;
    logic        active_q;
    logic [2:0]  note_q;

    function automatic logic [10:0] note_div(input logic [2:0] n);
        logic [10:0] base;
        logic [10:0] d;
        case (n)
            3'd0:    base = 11'd1433;
            3'd1:    base = 11'd1277;
            3'd2:    base = 11'd1138;
            3'd3:    base = 11'd1074;
            3'd4:    base = 11'd957;
            3'd5:    base = 11'd852;
            3'd6:    base = 11'd759;
            default: base = 11'd717;
        endcase
        d = base >> DIV_SHIFT;
        if (d < 11'd2) d = 11'd2;
        return d;
    endfunction

    // Lowest set key wins: scan from the top so the last hit is the lowest.
    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (ks[i]) sel = 3'(i);
        end
    end

    assign any_key  = |ks;
    assign cur_div  = note_div(note_q);
    assign tick_now = (state_q != IDLE) && (cnt == cur_div - 11'd1);
    assign wrap     = tick_now && (addr_q == 5'd31);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta <= '0;
            ks       <= '0;
        end else begin
            key_meta <= bus.key;
            ks       <= key_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt      <= '0;
            addr_q   <= '0;
            tick_q   <= 1'b0;
            active_q <= 1'b0;
            note_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    addr_q   <= '0;
                    cnt      <= '0;
                    tick_q   <= 1'b0;
                    active_q <= 1'b0;
                    if (any_key) begin
                        note_q   <= sel;
                        state_q  <= PLAY;
                        active_q <= 1'b1;
                    end
                end
                PLAY, RELEASE: begin
                    active_q <= 1'b1;
                    if (tick_now) begin
                        cnt    <= '0;
                        addr_q <= addr_q + 5'd1;
                        tick_q <= 1'b1;
                    end else begin
                        cnt    <= cnt + 11'd1;
                        tick_q <= 1'b0;
                    end
                    // Pitch and release decisions only land on the 31->0 step.
                    if (wrap) begin
                        if (any_key) begin
                            note_q  <= sel;
                            state_q <= PLAY;
                        end else if (state_q == PLAY) begin
                            state_q <= RELEASE;
                        end else begin
                            state_q  <= IDLE;
                            active_q <= 1'b0;
                        end
                    end else begin
                        state_q <= any_key ? PLAY : RELEASE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.addr        = addr_q;
    assign bus.sample_tick = tick_q;
    assign bus.note_active = active_q;
    assign bus.note_idx    = note_q;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_piano_note_addr_gen.sv
// Directed bench for piano_note_addr_gen with DIV_SHIFT=4 (A4=53, C4=89, C5=44 clocks per step).
module tb_piano_note_addr_gen;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    piano_note_addr_gen_if bus();

    piano_note_addr_gen #(
        .CLK_HZ   (12000000),
        .DIV_SHIFT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        bus.key = 8'h00;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic start_note(input logic [7:0] k);
        do_reset();
        bus.key = k;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_tick(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.sample_tick && n < budget);
    endtask

    task automatic wait_tick_mon(input int budget, output int n, inout int drops);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (!bus.note_active) drops++;
        end while (!bus.sample_tick && n < budget);
    endtask

    task automatic test_reset();
        int n;
        rst     = 1'b1;
        bus.key = 8'h00;
        repeat (2) @(negedge clk);
        checks++; if (bus.addr !== 5'd0) begin errors++; $display("FAIL reset_addr: got %0d expected 0", bus.addr); end
        checks++; if (bus.sample_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %0b expected 0", bus.sample_tick); end
        checks++; if (bus.note_active !== 1'b0) begin errors++; $display("FAIL reset_active: got %0b expected 0", bus.note_active); end
        checks++; if (bus.note_idx !== 3'd0) begin errors++; $display("FAIL reset_note_idx: got %0d expected 0", bus.note_idx); end
        checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
        rst = 1'b0;
        wait_tick(20, n);
        checks++; if (n != 20 || bus.note_active !== 1'b0 || bus.addr !== 5'd0) begin
            errors++; $display("FAIL idle_no_key: got n=%0d active=%0b addr=%0d expected n=20 active=0 addr=0", n, bus.note_active, bus.addr);
        end
    endtask

    task automatic test_a4_play();
        int n;
        int total;
        do_reset();
        bus.key = 8'h20;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.note_active !== 1'b0) begin errors++; $display("FAIL a4_active_early: got %0b expected 0", bus.note_active); end
        @(negedge clk);
        checks++; if (bus.note_active !== 1'b1) begin errors++; $display("FAIL a4_active: got %0b expected 1", bus.note_active); end
        checks++; if (bus.note_idx !== 3'd5) begin errors++; $display("FAIL a4_note_idx: got %0d expected 5", bus.note_idx); end
        checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL a4_state: got %0d expected 1", bus.state); end
        total = 0;
        for (int i = 1; i <= 32; i++) begin
            wait_tick(200, n);
            total += n;
            checks++; if (n != 53) begin errors++; $display("FAIL a4_spacing: step %0d got %0d expected 53", i, n); end
            checks++; if (bus.addr !== 5'(i % 32)) begin errors++; $display("FAIL a4_addr: step %0d got %0d expected %0d", i, bus.addr, i % 32); end
        end
        checks++; if (total != 1696) begin errors++; $display("FAIL a4_period: got %0d expected 1696", total); end
    endtask

    task automatic test_priority();
        int n;
        start_note(8'h81);
        checks++; if (bus.note_idx !== 3'd0) begin errors++; $display("FAIL prio_note_idx: got %0d expected 0", bus.note_idx); end
        checks++; if (bus.note_active !== 1'b1) begin errors++; $display("FAIL prio_active: got %0b expected 1", bus.note_active); end
        for (int i = 1; i <= 2; i++) begin
            wait_tick(200, n);
            checks++; if (n != 89) begin errors++; $display("FAIL prio_spacing: step %0d got %0d expected 89", i, n); end
        end
    endtask

    task automatic test_note_change();
        int n;
        start_note(8'h20);
        for (int i = 1; i <= 10; i++) wait_tick(200, n);
        checks++; if (bus.addr !== 5'd10) begin errors++; $display("FAIL chg_start_addr: got %0d expected 10", bus.addr); end
        bus.key = 8'h80;
        for (int i = 11; i <= 32; i++) begin
            wait_tick(200, n);
            checks++; if (n != 53) begin errors++; $display("FAIL chg_old_spacing: step %0d got %0d expected 53", i, n); end
            if (i == 31) begin
                checks++; if (bus.note_idx !== 3'd5) begin errors++; $display("FAIL chg_idx_before_wrap: got %0d expected 5", bus.note_idx); end
            end
        end
        checks++; if (bus.addr !== 5'd0) begin errors++; $display("FAIL chg_wrap_addr: got %0d expected 0", bus.addr); end
        checks++; if (bus.note_idx !== 3'd7) begin errors++; $display("FAIL chg_idx_at_wrap: got %0d expected 7", bus.note_idx); end
        for (int i = 1; i <= 2; i++) begin
            wait_tick(200, n);
            checks++; if (n != 44) begin errors++; $display("FAIL chg_new_spacing: step %0d got %0d expected 44", i, n); end
            checks++; if (bus.addr !== 5'(i)) begin errors++; $display("FAIL chg_new_addr: got %0d expected %0d", bus.addr, i); end
        end
    endtask

    task automatic test_release();
        int n;
        start_note(8'h20);
        for (int i = 1; i <= 12; i++) wait_tick(200, n);
        checks++; if (bus.addr !== 5'd12) begin errors++; $display("FAIL rel_start_addr: got %0d expected 12", bus.addr); end
        bus.key = 8'h00;
        for (int i = 13; i <= 32; i++) begin
            wait_tick(200, n);
            checks++; if (n != 53 || bus.addr !== 5'(i % 32)) begin
                errors++; $display("FAIL rel_step: step %0d got n=%0d addr=%0d expected n=53 addr=%0d", i, n, bus.addr, i % 32);
            end
            if (i == 13) begin
                checks++; if (bus.state !== 2'd2 || bus.note_active !== 1'b1) begin
                    errors++; $display("FAIL rel_state: got state=%0d active=%0b expected state=2 active=1", bus.state, bus.note_active);
                end
            end
        end
        checks++; if (bus.state !== 2'd0 || bus.note_active !== 1'b0) begin
            errors++; $display("FAIL rel_end: got state=%0d active=%0b expected state=0 active=0", bus.state, bus.note_active);
        end
        wait_tick(300, n);
        checks++; if (n != 300 || bus.sample_tick !== 1'b0 || bus.addr !== 5'd0) begin
            errors++; $display("FAIL rel_quiet: got n=%0d tick=%0b addr=%0d expected n=300 tick=0 addr=0", n, bus.sample_tick, bus.addr);
        end
        checks++; if (bus.note_idx !== 3'd5) begin errors++; $display("FAIL rel_idx_hold: got %0d expected 5", bus.note_idx); end
    endtask

    task automatic test_reentry();
        int n;
        int drops;
        start_note(8'h20);
        for (int i = 1; i <= 12; i++) wait_tick(200, n);
        bus.key = 8'h00;
        for (int i = 13; i <= 20; i++) wait_tick(200, n);
        checks++; if (bus.state !== 2'd2 || bus.addr !== 5'd20) begin
            errors++; $display("FAIL reent_pre: got state=%0d addr=%0d expected state=2 addr=20", bus.state, bus.addr);
        end
        bus.key = 8'h20;
        drops = 0;
        for (int i = 21; i <= 34; i++) begin
            wait_tick_mon(200, n, drops);
            checks++; if (n != 53 || bus.addr !== 5'(i % 32)) begin
                errors++; $display("FAIL reent_step: step %0d got n=%0d addr=%0d expected n=53 addr=%0d", i, n, bus.addr, i % 32);
            end
            if (i == 21 || i == 32) begin
                checks++; if (bus.state !== 2'd1 || bus.note_idx !== 3'd5) begin
                    errors++; $display("FAIL reent_state: step %0d got state=%0d idx=%0d expected state=1 idx=5", i, bus.state, bus.note_idx);
                end
            end
        end
        checks++; if (drops != 0) begin errors++; $display("FAIL reent_active_drop: got %0d expected 0", drops); end
    endtask

    task automatic test_async_reset();
        int n;
        start_note(8'h20);
        for (int i = 1; i <= 17; i++) wait_tick(200, n);
        checks++; if (bus.addr !== 5'd17) begin errors++; $display("FAIL arst_pre_addr: got %0d expected 17", bus.addr); end
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.addr !== 5'd0 || bus.note_active !== 1'b0 || bus.sample_tick !== 1'b0 || bus.state !== 2'd0) begin
            errors++; $display("FAIL arst_immediate: got addr=%0d active=%0b tick=%0b state=%0d expected all 0",
                bus.addr, bus.note_active, bus.sample_tick, bus.state);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.note_active !== 1'b0) begin errors++; $display("FAIL arst_resume_early: got %0b expected 0", bus.note_active); end
        @(negedge clk);
        checks++; if (bus.note_active !== 1'b1 || bus.note_idx !== 3'd5 || bus.addr !== 5'd0) begin
            errors++; $display("FAIL arst_resume: got active=%0b idx=%0d addr=%0d expected 1 5 0", bus.note_active, bus.note_idx, bus.addr);
        end
        wait_tick(200, n);
        checks++; if (n != 53 || bus.addr !== 5'd1) begin
            errors++; $display("FAIL arst_first_step: got n=%0d addr=%0d expected n=53 addr=1", n, bus.addr);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        bus.key = 8'h00;
        test_reset();
        test_a4_play();
        test_priority();
        test_note_change();
        test_release();
        test_reentry();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/piano_note_addr_gen.md
Name: piano_note_addr_gen

Overview:
- Upstream address generator for the 32-entry waveform ROM.
- Converts 8 piano key inputs (C4..C5) into a stepping 5-bit table address whose wrap rate equals the played note frequency.
- Ends every note on a full waveform cycle (addr returns to 0) so no click is produced.
- Its addr output drives the ROM address directly; the ROM registers data on the opposite clock edge.

Parameters:
- CLK_HZ, 12000000, system clock frequency; documents the divisor table below, not used in arithmetic.
- DIV_SHIFT, 0, right-shift applied to every note divisor; set nonzero only in simulation to shorten periods.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- key  in  8  raw key levels, bit0=C4 .. bit7=C5, asynchronous to clk
- addr  out  5  ROM address
- sample_tick  out  1  one-cycle pulse on the cycle addr advances
- note_active  out  1  high while state is PLAY or RELEASE
- note_idx  out  3  index of the note currently generating addr

Behaviour:
- Reset (async, rst=1): state=IDLE; addr=0, sample_tick=0, note_active=0, note_idx=0; divider count=0; synchroniser flops=0.
- Key input:
  - 2-flop synchroniser per bit, giving ks.
  - Priority encoder: lowest set bit of ks wins and gives the requested note sel.
  - any_key = |ks.
- Divisor table, as div = base >> DIV_SHIFT (11-bit unsigned):
  - C4 1433, D4 1277, E4 1138, F4 1074, G4 957, A4 852, B4 759, C5 717.
  - Base = round(CLK_HZ/(f*32)).
  - A shifted divisor below 2 is clamped to 2.
- Divider:
  - cnt counts 0..div-1 of the latched note_idx.
  - On the cycle cnt==div-1: cnt<=0, addr<=addr+1 (mod 32), sample_tick=1 (registered, coincident with the addr update).
  - Otherwise sample_tick=0.
- State IDLE:
  - addr=0, cnt=0, note_active=0.
  - If any_key: note_idx<=sel, cnt<=0, go to PLAY.
  - Latency: key stable before edge k makes note_active=1 after edge k+2.
- State PLAY:
  - Divider runs.
  - If !any_key: go to RELEASE (the divider keeps running, no reset of cnt/addr).
  - Note change takes effect only at the wrap step (addr 31->0). On that same edge note_idx<=sel and cnt<=0, so the new pitch starts on a clean cycle.
  - A key change seen mid-cycle, then reverted before the wrap, causes no change.
- State RELEASE:
  - Divider runs with the latched note_idx.
  - On the wrap step (addr 31->0): if !any_key go to IDLE (note_active<=0, note_idx holds its last value); if any_key go to PLAY with note_idx<=sel.
  - If any_key reappears before the wrap: return to PLAY immediately, without resetting cnt or addr; the pending note change applies at the wrap as in PLAY.
- Simultaneous events:
  - A wrap step on the same edge as key release in PLAY: the wrap completes (addr=0), then state goes to RELEASE and a full further cycle is played.
  - The wrap-time re-latch and the release check are evaluated on the same edge.
- Reset mid-note: addr, state and outputs are forced to their reset values immediately, without waiting for clk.
- addr never skips or repeats a value except via reset.

Test Plan:
- DIV_SHIFT=4. Assert rst, then release it. Hold key=8'b0010_0000 (A4, div=53).
  - Required: note_active=1 two edges after ks settles, note_idx=5.
  - sample_tick every 53 cycles; addr goes 0,1..31,0.
  - One full cycle = 1696 clk.
- DIV_SHIFT=4. Hold key=8'b1000_0001.
  - Required: priority gives note_idx=0 (C4, div=89); tick spacing is 89 cycles.
- DIV_SHIFT=4. Play A4; at addr=10 change key to bit7 (C5, div=44).
  - Required: spacing stays 53 until addr 31->0; on that edge note_idx=7.
  - Spacing is 44 from there on.
- DIV_SHIFT=4. Play A4; drop all keys at addr=12.
  - Required: note_active stays 1, addr continues to 31.
  - On the 31->0 step: IDLE, note_active=0, addr stays 0 with no more ticks.
- DIV_SHIFT=4. In RELEASE at addr=20, re-press A4.
  - Required: state returns to PLAY with no addr/cnt discontinuity; note_active never drops.
- DIV_SHIFT=4. Assert rst asynchronously (between clk edges) at addr=17 during PLAY.
  - Required: addr=0, note_active=0 and sample_tick=0 before the next clk edge.
  - After rst is released with the key still held, PLAY resumes two edges later.
